// File: rtl/music_player.sv
// music_player: steps the note ROM address at a fixed tempo, captures the
// returned note and turns it into a square wave on the speaker output.
module music_player #(
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned SONG_LEN    = 32,
  parameter int unsigned TONE_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       track_sel,
  output logic       music_sel,
  output logic [7:0] address,
  input  logic [7:0] note,
  output logic       speaker,
  output logic       beat,
  output logic       playing
);

  localparam int unsigned BW = $clog2(BEAT_CYCLES);

  // Last PLAY count of a slot; the two LOAD cycles complete BEAT_CYCLES.
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 3);
  // First PLAY count of the silent articulation gap.
  localparam logic [BW-1:0] GAP_START = BW'(BEAT_CYCLES - 2 - GAP_CYCLES);
  localparam logic [7:0]    ADDR_LAST = 8'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_e;

  // Octave-0 half-periods for C..B.
  function automatic logic [19:0] hp_base(input logic [3:0] s);
    logic [19:0] hp;
    case (s)
      4'd0:    hp = 20'd764409;
      4'd1:    hp = 20'd721500;
      4'd2:    hp = 20'd681013;
      4'd3:    hp = 20'd642797;
      4'd4:    hp = 20'd606722;
      4'd5:    hp = 20'd572672;
      4'd6:    hp = 20'd540532;
      4'd7:    hp = 20'd510197;
      4'd8:    hp = 20'd481566;
      4'd9:    hp = 20'd454545;
      4'd10:   hp = 20'd429033;
      default: hp = 20'd404953;
    endcase
    return hp;
  endfunction

  // Note 0 and anything above the table range are rests.
  function automatic logic is_audible(input logic [7:0] n);
    return (n != 8'd0) && (n < 8'd96);
  endfunction

  state_e      state_q,       state_d;
  logic        load_cnt_q,    load_cnt_d;
  logic [BW-1:0] beat_cnt_q,  beat_cnt_d;
  logic [19:0] tone_cnt_q,    tone_cnt_d;
  logic        tone_q,        tone_d;
  logic [19:0] half_period_q, half_period_d;
  logic [7:0]  note_q,        note_d;
  logic [7:0]  address_q,     address_d;
  logic        music_sel_q,   music_sel_d;
  logic        speaker_q,     speaker_d;
  logic        beat_q,        beat_d;
  logic        playing_q,     playing_d;

  logic [3:0]  semi;
  logic [2:0]  octave;
  logic [19:0] hp_shifted;
  logic [19:0] hp_calc;

  // Half-period for the note currently presented by the ROM.
  always_comb begin
    semi       = 4'(note % 8'd12);
    octave     = 3'(note / 8'd12);
    hp_shifted = hp_base(semi) >> (32'(octave) + TONE_SHIFT);
    hp_calc    = (hp_shifted == '0) ? 20'd1 : hp_shifted;
  end

  // Next-state logic for sequencer FSM, counters and registered outputs.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    tone_cnt_d    = tone_cnt_q;
    tone_d        = tone_q;
    half_period_d = half_period_q;
    note_d        = note_q;
    address_d     = address_q;
    music_sel_d   = music_sel_q;
    beat_d        = 1'b0;

    // Stop takes priority over everything else, including a slot end.
    if ((state_q != IDLE) && !enable) begin
      state_d    = IDLE;
      load_cnt_d = 1'b0;
      beat_cnt_d = '0;
      tone_cnt_d = '0;
      tone_d     = 1'b0;
      address_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          address_d  = '0;
          load_cnt_d = 1'b0;
          beat_cnt_d = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
          if (enable) begin
            music_sel_d = track_sel;
            state_d     = LOAD;
          end
        end

        LOAD: begin
          if (!load_cnt_q) begin
            load_cnt_d = 1'b1;
          end else begin
            note_d        = note;
            half_period_d = hp_calc;
            tone_cnt_d    = '0;
            tone_d        = 1'b0;
            beat_cnt_d    = '0;
            load_cnt_d    = 1'b0;
            state_d       = PLAY;
          end
        end

        PLAY: begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (tone_cnt_q == (half_period_q - 20'd1)) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 20'd1;
          end
          if (beat_cnt_q == BEAT_LAST) begin
            beat_d     = 1'b1;
            address_d  = (address_q == ADDR_LAST) ? '0 : address_q + 8'd1;
            load_cnt_d = 1'b0;
            state_d    = LOAD;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Speaker is registered from next-state values so it lines up with
    // the tone/gap state of the cycle it is visible in.
    speaker_d = (state_d == PLAY) && tone_d && (beat_cnt_d < GAP_START) &&
                is_audible(note_d);
    playing_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      load_cnt_q    <= 1'b0;
      beat_cnt_q    <= '0;
      tone_cnt_q    <= '0;
      tone_q        <= 1'b0;
      half_period_q <= '0;
      note_q        <= '0;
      address_q     <= '0;
      music_sel_q   <= 1'b0;
      speaker_q     <= 1'b0;
      beat_q        <= 1'b0;
      playing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      tone_cnt_q    <= tone_cnt_d;
      tone_q        <= tone_d;
      half_period_q <= half_period_d;
      note_q        <= note_d;
      address_q     <= address_d;
      music_sel_q   <= music_sel_d;
      speaker_q     <= speaker_d;
      beat_q        <= beat_d;
      playing_q     <= playing_d;
    end
  end

  assign music_sel = music_sel_q;
  assign address   = address_q;
  assign speaker   = speaker_q;
  assign beat      = beat_q;
  assign playing   = playing_q;

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player: ROM model with 1-cycle latency and a slot-position
// reference model of address, beat, speaker and playing.
module tb_music_player;

  localparam int unsigned B  = 20;
  localparam int unsigned G  = 4;
  localparam int unsigned L  = 4;
  localparam int unsigned TS = 14;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       track_sel;
  logic       music_sel;
  logic [7:0] address;
  logic [7:0] note;
  logic       speaker;
  logic       beat;
  logic       playing;

  always #5 clk = ~clk;

  music_player #(
    .BEAT_CYCLES(B),
    .GAP_CYCLES (G),
    .SONG_LEN   (L),
    .TONE_SHIFT (TS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .track_sel(track_sel),
    .music_sel(music_sel),
    .address  (address),
    .note     (note),
    .speaker  (speaker),
    .beat     (beat),
    .playing  (playing)
  );

  logic [7:0] rom [2][4];
  always @(posedge clk) note <= rom[music_sel][address[1:0]];

  int unsigned HP [12] = '{764409, 721500, 681013, 642797, 606722, 572672,
                           540532, 510197, 481566, 454545, 429033, 404953};

  int errors = 0;
  int checks = 0;

  // Model: playback is a count of cycles since the song started.
  bit          m_play = 1'b0;
  bit          m_sel  = 1'b0;
  int unsigned m_t    = 0;

  logic [7:0]  exp_addr;
  logic        exp_beat, exp_spk, exp_play, exp_sel;
  int unsigned exp_pos;

  task automatic model_eval();
    int unsigned slot, pos, k, hp, n;
    exp_sel = m_sel;
    exp_spk = 1'b0;
    if (!m_play) begin
      exp_addr = '0; exp_beat = 1'b0; exp_play = 1'b0; exp_pos = 0;
    end else begin
      slot     = m_t / B;
      pos      = m_t % B;
      exp_pos  = pos;
      exp_addr = 8'(slot % L);
      exp_beat = (pos == 0) && (slot != 0);
      exp_play = 1'b1;
      n        = int'(rom[m_sel][slot % L]);
      if (pos >= 2 && pos < B - G && n != 0 && n < 96) begin
        k  = pos - 2;
        hp = HP[n % 12] >> (n / 12 + TS);
        if (hp == 0) hp = 1;
        exp_spk = ((k / hp) % 2) == 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_play = 1'b0; m_sel = 1'b0;
    end else if (!m_play) begin
      if (enable) begin m_play = 1'b1; m_sel = track_sel; m_t = 0; end
    end else if (!enable) begin
      m_play = 1'b0;
    end else begin
      m_t++;
    end
    model_eval();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; track_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({address, speaker, beat, playing, music_sel} !== 12'b0)
        $display("FAIL reset_vals t=%0t got addr=%0d spk=%b beat=%b play=%b sel=%b exp all 0",
                 $time, address, speaker, beat, playing, music_sel);
      if ({address, speaker, beat, playing, music_sel} !== 12'b0) errors++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (playing !== 1'b1 || address !== 8'd0) begin
      errors++;
      $display("FAIL reset_release t=%0t got play=%b addr=%0d exp play=1 addr=0",
               $time, playing, address);
    end
  endtask

  task automatic test_tone();
    for (int i = 0; i < int'(4 * B); i++) begin
      tick();
      checks++;
      if (speaker !== exp_spk) begin
        errors++;
        $display("FAIL tone t=%0t pos=%0d got spk=%b exp %b", $time, exp_pos, speaker, exp_spk);
      end
    end
  endtask

  task automatic test_sequence();
    int last_beat = -1;
    int now = 0;
    for (int i = 0; i < int'(6 * B); i++) begin
      tick();
      now++;
      checks++;
      if (address !== exp_addr || beat !== exp_beat || playing !== exp_play) begin
        errors++;
        $display("FAIL sequence t=%0t got addr=%0d beat=%b play=%b exp addr=%0d beat=%b play=%b",
                 $time, address, beat, playing, exp_addr, exp_beat, exp_play);
      end
      if (beat === 1'b1) begin
        if (last_beat >= 0) begin
          checks++;
          if (now - last_beat != int'(B)) begin
            errors++;
            $display("FAIL beat_spacing t=%0t got %0d exp %0d", $time, now - last_beat, B);
          end
        end
        last_beat = now;
      end
    end
  endtask

  task automatic test_gap();
    for (int i = 0; i < int'(4 * B); i++) begin
      tick();
      if (exp_pos < 2 || exp_pos >= B - G) begin
        checks++;
        if (speaker !== 1'b0) begin
          errors++;
          $display("FAIL gap t=%0t pos=%0d got spk=%b exp 0", $time, exp_pos, speaker);
        end
      end
    end
  endtask

  task automatic test_track_sel();
    track_sel = 1'b1;
    for (int i = 0; i < int'(B + 3); i++) begin
      tick();
      checks++;
      if (music_sel !== 1'b0 || address !== exp_addr) begin
        errors++;
        $display("FAIL track_hold t=%0t got sel=%b addr=%0d exp sel=0 addr=%0d",
                 $time, music_sel, address, exp_addr);
      end
    end
    enable = 1'b0;
    tick();
    checks++;
    if (playing !== 1'b0 || address !== 8'd0) begin
      errors++;
      $display("FAIL track_stop t=%0t got play=%b addr=%0d exp play=0 addr=0", $time, playing, address);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (music_sel !== 1'b1 || address !== 8'd0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL track_restart t=%0t got sel=%b addr=%0d play=%b exp sel=1 addr=0 play=1",
               $time, music_sel, address, playing);
    end
    for (int i = 0; i < int'(L * B); i++) begin
      tick();
      checks++;
      if (speaker !== exp_spk || address !== exp_addr || beat !== exp_beat) begin
        errors++;
        $display("FAIL track1_play t=%0t got spk=%b addr=%0d beat=%b exp spk=%b addr=%0d beat=%b",
                 $time, speaker, address, beat, exp_spk, exp_addr, exp_beat);
      end
    end
  endtask

  task automatic test_stop_on_beat();
    int guard = 0;
    enable = 1'b1;
    while (exp_pos != B - 1 && guard < int'(3 * B)) begin
      tick();
      guard++;
    end
    checks++;
    if (exp_pos != B - 1 || address !== exp_addr) begin
      errors++;
      $display("FAIL stop_reach t=%0t got addr=%0d pos=%0d exp addr=%0d pos=%0d",
               $time, address, exp_pos, exp_addr, B - 1);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (beat !== 1'b0 || address !== 8'd0 || speaker !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL stop_on_beat t=%0t got beat=%b addr=%0d spk=%b play=%b exp all 0",
               $time, beat, address, speaker, playing);
    end
  endtask

  task automatic test_reset_mid_play();
    enable = 1'b1; track_sel = 1'b1;
    repeat ($urandom_range(5, 3 * B)) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({address, speaker, beat, playing, music_sel} !== 12'b0) begin
      errors++;
      $display("FAIL reset_mid t=%0t got addr=%0d spk=%b beat=%b play=%b sel=%b exp all 0",
               $time, address, speaker, beat, playing, music_sel);
    end
    reset = 1'b0; enable = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 59) != 0);
      track_sel = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (address !== exp_addr || beat !== exp_beat || speaker !== exp_spk ||
          playing !== exp_play || music_sel !== exp_sel) begin
        errors++;
        $display("FAIL random t=%0t got a=%0d b=%b s=%b p=%b m=%b exp a=%0d b=%b s=%b p=%b m=%b",
                 $time, address, beat, speaker, playing, music_sel,
                 exp_addr, exp_beat, exp_spk, exp_play, exp_sel);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    rom[0][0] = 8'd24; rom[0][1] = 8'd27; rom[0][2] = 8'd22; rom[0][3] = 8'd0;
    rom[1][0] = 8'($urandom_range(1, 95));
    for (int i = 1; i < 4; i++) rom[1][i] = 8'($urandom_range(0, 110));
    reset = 1'b1; enable = 1'b0; track_sel = 1'b0;
    model_eval();
    test_reset();
    test_tone();
    test_sequence();
    test_gap();
    test_track_sel();
    test_stop_on_beat();
    test_reset_mid_play();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
